e203_dsat_clip: RTL and testbench

Saturation write-back stage that consumes the per-lane top/bottom overflow flags from the dynamic-saturation detector and produces the clipped SIMD result for 8-, 16- or 32-bit lanes. Sits directly downstream of the overflow-detect logic in the DSP datapath and feeds the ALU write-back mux. One registered pipeline stage with a valid/ready handshake, a sticky overflow bit (P-extension OV semantics) and an optional saturation event counter.

---
 rtl/e203_dsat_clip_pkg.sv | 20 ++
 rtl/e203_dsat_clip_lane.sv | 38 +++
 rtl/e203_dsat_clip.sv | 135 +++++++++++++
 tb/tb_e203_dsat_clip.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_dsat_clip_pkg.sv
// Shared lane-size encodings and stage types for the dynamic-saturation clip stage.
package e203_dsat_clip_pkg;

  localparam int unsigned DSAT_XLEN = 32;

  // Size 2'b11 is treated like 2'b10 (32-bit lane).
  localparam logic [1:0] E203_DSAT_SZ_8  = 2'b00;
  localparam logic [1:0] E203_DSAT_SZ_16 = 2'b01;
  localparam logic [1:0] E203_DSAT_SZ_32 = 2'b10;

  typedef struct packed {
    logic [DSAT_XLEN-1:0] res;
    logic                 ov;
  } dsat_out_t;

  function automatic logic is_sz_32(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/e203_dsat_clip_lane.sv
// One W-bit saturation lane: replaces the lane by 2^n-1 or -(2^n) when the detector flagged overflow.
module e203_dsat_lane_clip #(
  parameter int W = 8
) (
  input  logic [W-1:0] op,
  input  logic [4:0]   n,
  input  logic         t_ov,
  input  logic         b_ov,
  output logic [W-1:0] res,
  output logic         clipped
);

  localparam logic [W-1:0] ONES = '1;
  localparam logic [5:0]   W6   = 6'(W);

  logic         pass;
  logic [5:0]   shamt;
  logic [W-1:0] hi;

  always_comb begin
    // n >= W-1 means the range covers the whole lane, so flags are meaningless.
    pass    = ({1'b0, n} >= (W6 - 6'd1));
    shamt   = W6 - {1'b0, n};
    hi      = ONES >> shamt;
    res     = op;
    clipped = 1'b0;
    if (!pass) begin
      if (t_ov) begin
        res     = hi;
        clipped = 1'b1;
      end else if (b_ov) begin
        res     = ~hi;
        clipped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e203_dsat_clip.sv
// Registered saturation write-back stage with sticky OV and an optional event counter.
// Optional feature: define E203_DSAT_CNT_EN to build the saturation event counter.
module e203_dsat_clip
  import e203_dsat_clip_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dsat_i_valid,
  output logic             dsat_i_ready,
  input  logic [31:0]      dsat_i_op,
  input  logic [1:0]       dsat_i_sz,
  input  logic [4:0]       dsat_i_n,
  input  logic             dsat_i_t_ov32,
  input  logic             dsat_i_b_ov32,
  input  logic [1:0]       dsat_i_t_ov16,
  input  logic [1:0]       dsat_i_b_ov16,
  input  logic [3:0]       dsat_i_t_ov8,
  input  logic [3:0]       dsat_i_b_ov8,
  output logic             dsat_o_valid,
  input  logic             dsat_o_ready,
  output logic [31:0]      dsat_o_res,
  output logic             dsat_o_ov,
  output logic             dsat_ov_sticky,
  input  logic             dsat_ov_clr,
  output logic [CNT_W-1:0] dsat_sat_cnt,
  input  logic             dsat_cnt_clr
);

  logic [31:0] res8;
  logic [31:0] res16;
  logic [31:0] res32;
  logic [3:0]  clip8;
  logic [1:0]  clip16;
  logic        clip32;
  dsat_out_t   nxt;
  logic        in_hs;
  logic        out_hs;

  for (genvar i = 0; i < 4; i++) begin : g_lane8
    e203_dsat_lane_clip #(.W(8)) u_lane (
      .op      (dsat_i_op[i*8 +: 8]),
      .n       (dsat_i_n),
      .t_ov    (dsat_i_t_ov8[i]),
      .b_ov    (dsat_i_b_ov8[i]),
      .res     (res8[i*8 +: 8]),
      .clipped (clip8[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane16
    e203_dsat_lane_clip #(.W(16)) u_lane (
      .op      (dsat_i_op[i*16 +: 16]),
      .n       (dsat_i_n),
      .t_ov    (dsat_i_t_ov16[i]),
      .b_ov    (dsat_i_b_ov16[i]),
      .res     (res16[i*16 +: 16]),
      .clipped (clip16[i])
    );
  end

  e203_dsat_lane_clip #(.W(32)) u_lane32 (
    .op      (dsat_i_op),
    .n       (dsat_i_n),
    .t_ov    (dsat_i_t_ov32),
    .b_ov    (dsat_i_b_ov32),
    .res     (res32),
    .clipped (clip32)
  );

  always_comb begin
    nxt.res = res32;
    nxt.ov  = clip32;
    if (!is_sz_32(dsat_i_sz)) begin
      if (dsat_i_sz == E203_DSAT_SZ_8) begin
        nxt.res = res8;
        nxt.ov  = |clip8;
      end else begin
        nxt.res = res16;
        nxt.ov  = |clip16;
      end
    end
  end

  // Handshake: a transfer happens on a clock edge where valid & ready are both 1;
  // valid never waits on ready, and the held output is frozen until it transfers.
  assign dsat_i_ready = ~dsat_o_valid | dsat_o_ready;
  assign in_hs        = dsat_i_valid & dsat_i_ready;
  assign out_hs       = dsat_o_valid & dsat_o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dsat_o_valid <= 1'b0;
      dsat_o_res   <= '0;
      dsat_o_ov    <= 1'b0;
    end else if (in_hs) begin
      dsat_o_valid <= 1'b1;
      dsat_o_res   <= nxt.res;
      dsat_o_ov    <= nxt.ov;
    end else if (out_hs) begin
      dsat_o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsat_ov_sticky <= 1'b0;
    end else if (out_hs && dsat_o_ov) begin
      dsat_ov_sticky <= 1'b1;
    end else if (dsat_ov_clr) begin
      dsat_ov_sticky <= 1'b0;
    end
  end

`ifdef E203_DSAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || dsat_cnt_clr) begin
      cnt_q <= '0;
    end else if (out_hs && dsat_o_ov && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dsat_sat_cnt = cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = dsat_cnt_clr;
  assign dsat_sat_cnt   = '0;
`endif

endmodule

// File: tb/tb_e203_dsat_clip.sv
// Self-checking bench for e203_dsat_clip: arithmetic reference model plus directed vectors.
module tb_e203_dsat_clip;

  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] op;
    logic [1:0]  sz;
    logic [4:0]  n;
    logic [3:0]  t8;
    logic [3:0]  b8;
    logic [1:0]  t16;
    logic [1:0]  b16;
    logic        t32;
    logic        b32;
    logic [31:0] res;
    logic        ov;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             dsat_i_valid;
  logic             dsat_i_ready;
  logic [31:0]      dsat_i_op;
  logic [1:0]       dsat_i_sz;
  logic [4:0]       dsat_i_n;
  logic             dsat_i_t_ov32;
  logic             dsat_i_b_ov32;
  logic [1:0]       dsat_i_t_ov16;
  logic [1:0]       dsat_i_b_ov16;
  logic [3:0]       dsat_i_t_ov8;
  logic [3:0]       dsat_i_b_ov8;
  logic             dsat_o_valid;
  logic             dsat_o_ready;
  logic [31:0]      dsat_o_res;
  logic             dsat_o_ov;
  logic             dsat_ov_sticky;
  logic             dsat_ov_clr;
  logic [CNT_W-1:0] dsat_sat_cnt;
  logic             dsat_cnt_clr;

  e203_dsat_clip #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .dsat_i_valid   (dsat_i_valid),
    .dsat_i_ready   (dsat_i_ready),
    .dsat_i_op      (dsat_i_op),
    .dsat_i_sz      (dsat_i_sz),
    .dsat_i_n       (dsat_i_n),
    .dsat_i_t_ov32  (dsat_i_t_ov32),
    .dsat_i_b_ov32  (dsat_i_b_ov32),
    .dsat_i_t_ov16  (dsat_i_t_ov16),
    .dsat_i_b_ov16  (dsat_i_b_ov16),
    .dsat_i_t_ov8   (dsat_i_t_ov8),
    .dsat_i_b_ov8   (dsat_i_b_ov8),
    .dsat_o_valid   (dsat_o_valid),
    .dsat_o_ready   (dsat_o_ready),
    .dsat_o_res     (dsat_o_res),
    .dsat_o_ov      (dsat_o_ov),
    .dsat_ov_sticky (dsat_ov_sticky),
    .dsat_ov_clr    (dsat_ov_clr),
    .dsat_sat_cnt   (dsat_sat_cnt),
    .dsat_cnt_clr   (dsat_cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint clip_lane(input longint val, input int w, input int n,
                                       input bit t, input bit b, output bit c);
    c = 1'b0;
    if (n >= w - 1 || (!t && !b)) return val;
    c = 1'b1;
    if (t) return (longint'(1) << n) - 1;
    return (longint'(1) << w) - (longint'(1) << n);
  endfunction

  function automatic logic [31:0] model(input vec_t v, output logic ov);
    int     w;
    longint acc;
    longint lane;
    bit     t;
    bit     b;
    bit     c;
    w   = (v.sz == 2'd0) ? 8 : (v.sz == 2'd1) ? 16 : 32;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < 32 / w; i++) begin
      lane = (longint'(v.op) >> (i * w)) & ((longint'(1) << w) - 1);
      t = (w == 8) ? v.t8[i] : (w == 16) ? v.t16[i] : v.t32;
      b = (w == 8) ? v.b8[i] : (w == 16) ? v.b16[i] : v.b32;
      lane = clip_lane(lane, w, int'(v.n), t, b, c);
      acc = acc | (lane << (i * w));
      ov  = ov | c;
    end
    return acc[31:0];
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [31:0] exp_q[$];
  logic        exp_ov_q[$];
  bit          model_on = 1'b0;
  bit          m_sticky;
  int          m_cnt;

  always @(negedge clk) begin
    vec_t cur;
    logic cur_ov;
    bit   out_hs;
    bit   hs_ov;
    bit   in_hs;
    if (model_on) begin
      check("o_valid", 32'(dsat_o_valid), 32'(exp_q.size() != 0));
      check("i_ready", 32'(dsat_i_ready), 32'(exp_q.size() == 0 || dsat_o_ready));
      if (exp_q.size() != 0) begin
        check("o_res", dsat_o_res, exp_q[0]);
        check("o_ov", 32'(dsat_o_ov), 32'(exp_ov_q[0]));
      end
      check("ov_sticky", 32'(dsat_ov_sticky), 32'(m_sticky));
      check("sat_cnt", 32'(dsat_sat_cnt), 32'(m_cnt));
    end
    if (rst) begin
      exp_q.delete();
      exp_ov_q.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      out_hs = (exp_q.size() != 0) && dsat_o_ready;
      hs_ov  = out_hs && exp_ov_q[0];
      in_hs  = dsat_i_valid && ((exp_q.size() == 0) || dsat_o_ready);
      if (out_hs) begin
        void'(exp_q.pop_front());
        void'(exp_ov_q.pop_front());
      end
      if (in_hs) begin
        cur = '{dsat_i_op, dsat_i_sz, dsat_i_n, dsat_i_t_ov8, dsat_i_b_ov8,
                dsat_i_t_ov16, dsat_i_b_ov16, dsat_i_t_ov32, dsat_i_b_ov32, 32'h0, 1'b0};
        exp_q.push_back(model(cur, cur_ov));
        exp_ov_q.push_back(cur_ov);
      end
      if (hs_ov) m_sticky = 1'b1;
      else if (dsat_ov_clr) m_sticky = 1'b0;
`ifdef E203_DSAT_CNT_EN
      if (dsat_cnt_clr) m_cnt = 0;
      else if (hs_ov && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    int budget;
    budget        = 0;
    dsat_i_valid  = 1'b1;
    dsat_i_op     = v.op;
    dsat_i_sz     = v.sz;
    dsat_i_n      = v.n;
    dsat_i_t_ov8  = v.t8;
    dsat_i_b_ov8  = v.b8;
    dsat_i_t_ov16 = v.t16;
    dsat_i_b_ov16 = v.b16;
    dsat_i_t_ov32 = v.t32;
    dsat_i_b_ov32 = v.b32;
    forever begin
      @(negedge clk);
      if (dsat_i_ready) break;
      budget++;
      if (budget > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=i_ready_low expected=accept t=%0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    dsat_i_valid = 1'b0;
    dsat_i_op    = 32'($urandom_range(0, 32'hFFFF));
  endtask

  // ---------------- directed stimulus ----------------
  vec_t vecs[11];

  initial begin
    logic pin_ov;
    logic [31:0] pin_res;
    vecs[0]  = '{32'h7F80_0510, 2'd0, 5'd3,  4'b1000, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0, 32'h07F8_0510, 1'b1};
    vecs[1]  = '{32'h8000_7FFF, 2'd1, 5'd15, 4'b1111, 4'b1111, 2'b11, 2'b11, 1'b1, 1'b1, 32'h8000_7FFF, 1'b0};
    vecs[2]  = '{32'hFFFF_0000, 2'd2, 5'd7,  4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[3]  = '{32'h1234_5678, 2'd1, 5'd4,  4'b0000, 4'b0000, 2'b01, 2'b10, 1'b0, 1'b0, 32'hFFF0_000F, 1'b1};
    vecs[4]  = '{32'hDEAD_BEEF, 2'd0, 5'd7,  4'b1111, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{32'h1234_5678, 2'd3, 5'd0,  4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h0000_0000, 2'd0, 5'd0,  4'b0000, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{32'h0000_0000, 2'd2, 5'd30, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 32'h3FFF_FFFF, 1'b1};
    vecs[8]  = '{32'h8000_0000, 2'd2, 5'd31, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'hAAAA_5555, 2'd1, 5'd14, 4'b0000, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b0, 32'h3FFF_5555, 1'b1};
    vecs[10] = '{32'h0102_0304, 2'd0, 5'd6,  4'b0000, 4'b0000, 2'b11, 2'b11, 1'b1, 1'b1, 32'h0102_0304, 1'b0};

    rst = 1'b1;
    dsat_i_valid = 1'b0;
    dsat_i_op = '0; dsat_i_sz = '0; dsat_i_n = '0;
    dsat_i_t_ov8 = '0; dsat_i_b_ov8 = '0; dsat_i_t_ov16 = '0; dsat_i_b_ov16 = '0;
    dsat_i_t_ov32 = 1'b0; dsat_i_b_ov32 = 1'b0;
    dsat_o_ready = 1'b1;
    dsat_ov_clr = 1'b0;
    dsat_cnt_clr = 1'b0;

    // Pin the reference model to the hand-computed table.
    foreach (vecs[i]) begin
      pin_res = model(vecs[i], pin_ov);
      check($sformatf("model_res_v%0d", i), pin_res, vecs[i].res);
      check($sformatf("model_ov_v%0d", i), 32'(pin_ov), 32'(vecs[i].ov));
    end

    idle(2);
    rst = 1'b0;
    check("reset_res", dsat_o_res, 32'h0);
    check("reset_valid", 32'(dsat_o_valid), 32'h0);
    check("reset_sticky", 32'(dsat_ov_sticky), 32'h0);
    check("reset_cnt", 32'(dsat_sat_cnt), 32'h0);

    send(vecs[0]);
    check("first_res", dsat_o_res, 32'h07F8_0510);
    idle(1);
    check("sticky_after_clip", 32'(dsat_ov_sticky), 32'h1);
    for (int i = 1; i < 11; i++) send(vecs[i]);
    idle(2);

    // Backpressure: one result held, a second waiting at the input.
    dsat_o_ready = 1'b0;
    send(vecs[3]);
    fork
      send(vecs[9]);
      begin
        repeat (3) begin
          check("held_res", dsat_o_res, 32'hFFF0_000F);
          check("held_i_ready", 32'(dsat_i_ready), 32'h0);
          @(posedge clk);
          #1;
        end
        dsat_o_ready = 1'b1;
      end
    join
    check("second_res", dsat_o_res, 32'h3FFF_5555);
    idle(2);

    // Clear and set of sticky in the same cycle: set wins.
    send(vecs[0]);
    dsat_ov_clr = 1'b1;
    idle(1);
    dsat_ov_clr = 1'b0;
    check("sticky_set_wins", 32'(dsat_ov_sticky), 32'h1);
    dsat_ov_clr = 1'b1;
    idle(1);
    dsat_ov_clr = 1'b0;
    check("sticky_cleared", 32'(dsat_ov_sticky), 32'h0);

    // Reset while a result is held discards it.
    dsat_o_ready = 1'b0;
    send(vecs[2]);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midreset_valid", 32'(dsat_o_valid), 32'h0);
    check("midreset_res", dsat_o_res, 32'h0);
    check("midreset_sticky", 32'(dsat_ov_sticky), 32'h0);
    dsat_o_ready = 1'b1;
    idle(1);

    // Counter saturation and clear-over-increment.
    for (int i = 0; i < 17; i++) send(vecs[0]);
    idle(1);
`ifdef E203_DSAT_CNT_EN
    check("cnt_saturated", 32'(dsat_sat_cnt), 32'hF);
`else
    check("cnt_tied_zero", 32'(dsat_sat_cnt), 32'h0);
`endif
    send(vecs[0]);
    dsat_cnt_clr = 1'b1;
    idle(1);
    dsat_cnt_clr = 1'b0;
    check("cnt_clear_wins", 32'(dsat_sat_cnt), 32'h0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
